// File: rtl/reduce_mod3329_arbiter.sv
// reduce_mod3329_arbiter: round-robin sharing of one mod-Q reducer among N_REQ requesters.
// Optional RUN watchdog enabled by defining REDUCE_ARB_TIMEOUT_EN.
module reduce_mod3329_arbiter #(
  parameter int N_REQ       = 4,
  parameter int Q           = 3329,
  parameter int A_W         = 24,
  parameter int R_W         = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ*A_W-1:0] req_a_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   rsp_valid_o,
  output logic [R_W-1:0]     rsp_r_o,
  output logic               rsp_err_o,
  input  logic [N_REQ-1:0]   rsp_ready_i,
  output logic               red_start_o,
  output logic [A_W-1:0]     red_a_o,
  input  logic               red_done_i,
  input  logic [R_W-1:0]     red_r_i,
  output logic               busy_o
);
  localparam int P_W = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
  state_t state, state_n;
  logic [P_W-1:0] rr_ptr, id, grant;
  logic found, xfer, tmo;
  logic [A_W-1:0] op;
  logic [R_W-1:0] res;
  function automatic logic [P_W-1:0] wrap(input int v);
    return P_W'(v >= N_REQ ? v - N_REQ : v);
  endfunction
  // descending scan so the candidate closest to rr_ptr is written last and wins
  always_comb begin
    found = 1'b0;
    grant = rr_ptr;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req_valid_i[wrap(int'(rr_ptr) + i)]) begin
        found = 1'b1;
        grant = wrap(int'(rr_ptr) + i);
      end
  end
  assign req_ready_o = (state == IDLE && found && !rst_i) ? N_REQ'(1) << grant : '0;
  assign xfer = |(req_valid_i & req_ready_o);
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = xfer ? RUN : IDLE;
      RUN:     state_n = (red_done_i || tmo) ? RESP : RUN;
      RESP:    state_n = rsp_ready_i[id] ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rr_ptr <= '0;
      id     <= '0;
      op     <= '0;
      res    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && xfer) begin
        id <= grant;
        op <= req_a_i[grant*A_W +: A_W];
      end
      if (state == RUN && (red_done_i || tmo))
        res <= !red_done_i ? '0 : red_r_i >= R_W'(Q) ? red_r_i - R_W'(Q) : red_r_i;
      if (state == RESP && rsp_ready_i[id])
        rr_ptr <= wrap(int'(id) + 1);
    end
  end
`ifdef REDUCE_ARB_TIMEOUT_EN
  localparam int C_W = $clog2(TIMEOUT_CYC + 1);
  logic [C_W-1:0] cnt;
  logic err;
  always_ff @(posedge clk_i) begin
    if (rst_i || state != RUN)
      cnt <= '0;
    else
      cnt <= cnt + C_W'(1);
    if (rst_i)
      err <= 1'b0;
    else if (state == RUN && tmo)
      err <= 1'b1;
    else if (state == RESP && rsp_ready_i[id])
      err <= 1'b0;
  end
  assign tmo = state == RUN && !red_done_i && cnt == C_W'(TIMEOUT_CYC - 1);
  assign rsp_err_o = state == RESP && err;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign tmo = 1'b0;
  assign rsp_err_o = 1'b0;
`endif
  assign busy_o      = state != IDLE;
  assign red_start_o = state == RUN;
  assign red_a_o     = state == RUN ? op : '0;
  assign rsp_valid_o = state == RESP ? N_REQ'(1) << id : '0;
  assign rsp_r_o     = state == RESP ? res : '0;
endmodule

// File: tb/tb_reduce_mod3329_arbiter.sv
// tb_reduce_mod3329_arbiter: scoreboard bench with a latency-configurable reducer model.
module tb_reduce_mod3329_arbiter;
  localparam int N = 4, Q = 3329, A_W = 24, R_W = 12;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N*A_W-1:0] req_a = '0;
  logic [R_W-1:0] rsp_r, red_r = '0;
  logic rsp_err, red_start, red_done = 0, busy;
  logic [A_W-1:0] red_a;

  reduce_mod3329_arbiter dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_a_i(req_a),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_r_o(rsp_r),
    .rsp_err_o(rsp_err), .rsp_ready_i(rsp_ready), .red_start_o(red_start),
    .red_a_o(red_a), .red_done_i(red_done), .red_r_i(red_r), .busy_o(busy)
  );

  int checks = 0, errors = 0, cyc = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;

  // reducer model: done rises rlat cycles after start, may return exactly Q for multiples of Q
  int lat_cfg = 1, rlat = 1, rcnt = 0, force_val = 0;
  bit force_en = 0;
  function automatic logic [R_W-1:0] model_r(input logic [A_W-1:0] a);
    int m;
    m = int'(a) % Q;
    if (force_en) return R_W'(force_val);
    return (m == 0 && a[0]) ? R_W'(Q) : R_W'(m);
  endfunction
  function automatic int exp_of(input logic [A_W-1:0] a);
    return force_en ? force_val % Q : int'(a) % Q;
  endfunction
  always @(posedge clk) begin
    if (!red_start) begin
      rcnt <= 0;
      red_done <= 0;
      rlat <= lat_cfg;
    end else begin
      rcnt <= rcnt + 1;
      red_done <= (rcnt + 1 >= rlat);
      red_r <= model_r(red_a);
    end
  end

  // monitor / scoreboard
  int exp_q[N][$];
  int glog[$];
  int exp_ptr = 0, acc_cyc = 0, hold_k = 0, mon_g, mon_k, rsp_seen = 0;
  bit inflight = 0, hold = 0;
  logic [R_W-1:0] hold_r;
  logic [N-1:0] acc_flag = '0;
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) exp_q[k].delete();
      exp_ptr = 0; inflight = 0; hold = 0; acc_flag = '0;
    end else begin
      chk("busy", busy, inflight);
      chk("red_start", red_start, inflight && rsp_valid == '0);
      chk("rsp_err", rsp_err, 0);
      acc_flag = req_valid & req_ready;
      if (inflight) chk("ready_while_busy", req_ready, 0);
      else begin
        mon_g = -1;
        for (int i = 0; i < N; i++)
          if (mon_g < 0 && req_valid[(exp_ptr + i) % N]) mon_g = (exp_ptr + i) % N;
        chk("grant", req_ready, mon_g < 0 ? 0 : (1 << mon_g));
        if (acc_flag != '0 && mon_g >= 0) begin
          exp_q[mon_g].push_back(exp_of(req_a[mon_g*A_W +: A_W]));
          glog.push_back(mon_g);
          inflight = 1;
          acc_cyc = cyc;
        end
      end
      if (rsp_valid != '0) begin
        chk("rsp_onehot", $onehot(rsp_valid), 1);
        mon_k = 0;
        for (int i = 0; i < N; i++) if (rsp_valid[i]) mon_k = i;
        if (hold) begin
          chk("hold_idx", mon_k, hold_k);
          chk("hold_r", rsp_r, hold_r);
        end else begin
          rsp_seen++;
          chk("rsp_latency", cyc - acc_cyc, rlat + 2);
          chk("rsp_expected", exp_q[mon_k].size() > 0, 1);
          if (exp_q[mon_k].size() > 0) chk("rsp_r", rsp_r, exp_q[mon_k][0]);
        end
        if (rsp_ready[mon_k]) begin
          hold = 0;
          if (exp_q[mon_k].size() > 0) void'(exp_q[mon_k].pop_front());
          exp_ptr = (mon_k + 1) % N;
          inflight = 0;
        end else begin
          hold = 1; hold_k = mon_k; hold_r = rsp_r;
        end
      end else if (hold) begin
        chk("hold_valid", rsp_valid, 1 << hold_k);
        hold = 0;
      end
    end
  end

  task automatic drv(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); #1; endtask
  task automatic set_req(input int k, input logic [A_W-1:0] a);
    req_valid[k] = 1'b1;
    req_a[k*A_W +: A_W] = a;
  endtask
  function automatic logic [A_W-1:0] rnd_a();
    return ($urandom % 4 == 0) ? A_W'(Q * $urandom_range(0, 5000)) : A_W'($urandom);
  endfunction
  task automatic chk_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_start"}, red_start, 0);
    chk({name, "_red_a"}, red_a, 0);
    chk({name, "_rsp_valid"}, rsp_valid, 0);
    chk({name, "_rsp_r"}, rsp_r, 0);
    chk({name, "_rsp_err"}, rsp_err, 0);
    chk({name, "_ready"}, req_ready, 0);
  endtask
  task automatic do_reset();
    drv();
    rst = 1; req_valid = '0; rsp_ready = '0;
    repeat (2) drv();
    rst = 0;
  endtask
  int t_acc, t_rsp;
  task automatic issue(input int k, input logic [A_W-1:0] a);
    bit ok;
    drv();
    set_req(k, a);
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin smp(); ok = acc_flag[k]; end
    chk("accept", ok, 1);
    t_acc = cyc;
    drv();
    req_valid[k] = 1'b0;
  endtask
  task automatic wait_rsp(input int k);
    bit ok;
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin smp(); ok = rsp_valid[k]; end
    chk("rsp_arrived", ok, 1);
    t_rsp = cyc;
  endtask
  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      drv();
      req_valid = req_valid & ~acc_flag;
      ok = (req_valid == '0) && !busy;
    end
    chk(name, ok, 1);
  endtask

  logic [R_W-1:0] r0;
  int n0;
  initial begin
    do_reset();
    smp();
    chk_zero("reset");
    // single request, minimum latency
    lat_cfg = 1; rsp_ready = '1;
    issue(0, 24'd10000);
    wait_rsp(0);
    chk("single_r", rsp_r, 13);
    chk("single_valid", rsp_valid, 4'b0001);
    chk("single_err", rsp_err, 0);
    chk("single_latency", t_rsp - t_acc, 3);
    // reducer returning exactly Q and Q-1
    force_en = 1; force_val = 3329;
    issue(1, rnd_a());
    wait_rsp(1);
    chk("qcorr_q", rsp_r, 0);
    force_val = 3328;
    issue(2, rnd_a());
    wait_rsp(2);
    chk("qcorr_qm1", rsp_r, 3328);
    force_en = 0;
    // round-robin with all requesters holding valid
    do_reset();
    glog.delete();
    rsp_ready = '1; lat_cfg = 1;
    drv();
    for (int k = 0; k < N; k++) set_req(k, rnd_a());
    for (int i = 0; i < 100 && glog.size() < 5; i++) smp();
    drv();
    req_valid = '0;
    chk("rr_count", glog.size() >= 5, 1);
    for (int i = 0; i < 5; i++) if (glog.size() > i) chk("rr_order", glog[i], i % N);
    wait_idle("rr_drain");
    // back-pressure on requester 2 with others waiting
    rsp_ready = 4'b1011; lat_cfg = 2;
    issue(2, rnd_a());
    set_req(0, rnd_a());
    set_req(1, rnd_a());
    wait_rsp(2);
    r0 = rsp_r;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("bp_valid", rsp_valid, 4'b0100);
      chk("bp_r", rsp_r, r0);
      chk("bp_start", red_start, 0);
      chk("bp_ready", req_ready, 0);
    end
    drv();
    rsp_ready = '1;
    wait_idle("bp_drain");
    // reset while the reducer is running
    lat_cfg = 6;
    issue(3, rnd_a());
    chk("rst_run_start", red_start, 1);
    rst = 1;
    drv();
    rst = 0;
    smp();
    chk_zero("rst_run");
    n0 = rsp_seen;
    repeat (20) smp();
    chk("rst_abandoned", rsp_seen, n0);
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drv();
      req_valid = req_valid & ~acc_flag;
      lat_cfg = $urandom_range(1, 6);
      rsp_ready = N'($urandom);
      for (int k = 0; k < N; k++)
        if (!req_valid[k] && $urandom % 4 == 0) set_req(k, rnd_a());
        else if (req_valid[k] && $urandom % 16 == 0) req_valid[k] = 1'b0;
    end
    drv();
    req_valid = '0;
    rsp_ready = '1;
    wait_idle("final_drain");
    for (int k = 0; k < N; k++) chk("final_queue_empty", exp_q[k].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
